// File: rtl/o2_clk_pkg.sv
// Shared types and default divisors for the Odyssey2 clock-enable generator.
// PAL divisors are only referenced when O2_CLK_PAL_EN is defined.
package o2_clk_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int NTSC_CPU_DIV  = 8;
  localparam int NTSC_VDC_DIV  = 6;
  localparam int CB_DIV_DEF    = 12;
  localparam int PAL_CPU_DIV   = 7;
  localparam int PAL_VDC_DIV   = 5;
  localparam int LOCK_HOLD_DEF = 1024;

endpackage

// File: rtl/o2_ce_div.sv
// Single clock-enable divider: free-running modulo counter in RUN, registered
// one-cycle pulse on wrap. O2_CLK_PAL_EN adds an alternate divisor selected by alt.
module o2_ce_div
  import o2_clk_pkg::*;
#(
`ifdef O2_CLK_PAL_EN
  parameter int DIV_ALT = 8,
`endif
  parameter int DIV = 8
)(
  input  logic clk_sys,
  input  logic rst_n,
`ifdef O2_CLK_PAL_EN
  input  logic alt,
`endif
  input  logic run,
  input  logic mask,
  output logic ce
);

`ifdef O2_CLK_PAL_EN
  localparam int DMAX = (DIV_ALT > DIV) ? DIV_ALT : DIV;
  if (DIV_ALT < 2 || DIV_ALT > 256) begin : g_bad_div_alt
    $error("o2_ce_div: DIV_ALT=%0d outside 2..256", DIV_ALT);
  end
`else
  localparam int DMAX = DIV;
`endif
  localparam int CW = $clog2(DMAX);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2 || DIV > 256) begin : g_bad_div
    $error("o2_ce_div: DIV=%0d outside 2..256", DIV);
  end

  logic [CW-1:0] r_cnt;
  logic          r_ce;
  logic          w_last;

`ifdef O2_CLK_PAL_EN
  localparam logic [CW-1:0] LAST_ALT = CW'(DIV_ALT - 1);
  assign w_last = alt ? (r_cnt == LAST_ALT) : (r_cnt == LAST);
`else
  assign w_last = (r_cnt == LAST);
`endif

  // Dropping run zeroes the counter so every RUN period starts on the same phase.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ce  <= 1'b0;
    end else if (!run) begin
      r_cnt <= '0;
      r_ce  <= 1'b0;
    end else begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      r_ce  <= w_last & ~mask;
    end
  end

  assign ce = r_ce;

endmodule

// File: rtl/o2_clk_ce_gen.sv
// Lock-qualified core reset and phase-aligned CPU/VDC/colour-burst clock enables.
// Define O2_CLK_PAL_EN to add the pal input and PAL divisor set.
module o2_clk_ce_gen
  import o2_clk_pkg::*;
#(
`ifdef O2_CLK_PAL_EN
  parameter int CPU_DIV_PAL = PAL_CPU_DIV,
  parameter int VDC_DIV_PAL = PAL_VDC_DIV,
`endif
  parameter int CPU_DIV   = NTSC_CPU_DIV,
  parameter int VDC_DIV   = NTSC_VDC_DIV,
  parameter int CB_DIV    = CB_DIV_DEF,
  parameter int LOCK_HOLD = LOCK_HOLD_DEF,
  parameter int CNT_W     = 11
)(
  input  logic clk_sys,
  input  logic rst_n,
`ifdef O2_CLK_PAL_EN
  input  logic pal,
`endif
  input  logic pll_locked,
  input  logic reset_req,
  input  logic pause,
  output logic core_rst_n,
  output logic ce_cpu,
  output logic ce_vdc,
  output logic ce_cb,
  output logic running
);

  if (LOCK_HOLD < 1 || LOCK_HOLD > (1 << CNT_W)) begin : g_bad_hold
    $error("o2_clk_ce_gen: LOCK_HOLD=%0d does not fit CNT_W=%0d", LOCK_HOLD, CNT_W);
  end

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LOCK_HOLD - 1);

  logic             r_sync1, r_lk_s;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic             w_ok, w_run;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_lk_s  <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_lk_s  <= r_sync1;
    end
  end

  assign w_ok = r_lk_s & ~reset_req;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HOLD;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  // Any dropout of the lock/no-request condition restarts the hold count.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = '0;
    case (r_state)
      HOLD: begin
        if (w_ok) begin
          if (r_hold_cnt == HOLD_LAST) w_state_nxt    = RUN;
          else                         w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!w_ok) w_state_nxt = HOLD;
      end
      default: w_state_nxt = HOLD;
    endcase
  end

  // Dividers count only while staying in RUN: idle on the entry cycle, and
  // cleared on the exit edge so no enable escapes into HOLD.
  assign w_run      = (r_state == RUN) && (w_state_nxt == RUN);
  assign core_rst_n = (r_state == RUN);
  assign running    = (r_state == RUN);

`ifdef O2_CLK_PAL_EN
  logic r_pal;

  // Tracks pal in HOLD; the value captured on the entry edge holds for the RUN period.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                r_pal <= 1'b0;
    else if (r_state == HOLD)  r_pal <= pal;
  end

  o2_ce_div #(.DIV(CPU_DIV), .DIV_ALT(CPU_DIV_PAL)) u_div_cpu (
    .clk_sys(clk_sys), .rst_n(rst_n), .alt(r_pal), .run(w_run), .mask(pause),  .ce(ce_cpu)
  );
  o2_ce_div #(.DIV(VDC_DIV), .DIV_ALT(VDC_DIV_PAL)) u_div_vdc (
    .clk_sys(clk_sys), .rst_n(rst_n), .alt(r_pal), .run(w_run), .mask(1'b0),   .ce(ce_vdc)
  );
  o2_ce_div #(.DIV(CB_DIV), .DIV_ALT(CB_DIV)) u_div_cb (
    .clk_sys(clk_sys), .rst_n(rst_n), .alt(1'b0),  .run(w_run), .mask(1'b0),   .ce(ce_cb)
  );
`else
  o2_ce_div #(.DIV(CPU_DIV)) u_div_cpu (
    .clk_sys(clk_sys), .rst_n(rst_n), .run(w_run), .mask(pause), .ce(ce_cpu)
  );
  o2_ce_div #(.DIV(VDC_DIV)) u_div_vdc (
    .clk_sys(clk_sys), .rst_n(rst_n), .run(w_run), .mask(1'b0),  .ce(ce_vdc)
  );
  o2_ce_div #(.DIV(CB_DIV)) u_div_cb (
    .clk_sys(clk_sys), .rst_n(rst_n), .run(w_run), .mask(1'b0),  .ce(ce_cb)
  );
`endif

endmodule
